approx_mult_error_monitor: RTL
==============================

Name: approx_mult_error_monitor

Overview:
Sequential consumer placed directly downstream of the 8x8 approximate multiplier. It takes each operand pair together with the approximate product, computes the exact product internally, and measures the error distance for that sample. Over a fixed window of samples it accumulates error statistics, then reports them through a valid/ready handshake. It provides in-silicon and bench characterisation of multiplier accuracy.

Parameters:
WIDTH, 8, operand width; product width PW = 2*WIDTH.
WINDOW, 256, samples per measurement window; must be >= 1.
ACC_W, 32, width of the saturating error-sum accumulator; must be >= PW.
CNT_W, 9, counter width; must satisfy 2^CNT_W > WINDOW.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that opens a window; honoured only in IDLE
in_valid  in  1  sample present
in_ready  out  1  block accepts a sample this cycle
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
in_approx  in  PW  approximate product for (in_a, in_b)
busy  out  1  high in RUN, DRAIN and REPORT
res_valid  out  1  results valid
res_ready  in  1  consumer takes results
err_count  out  CNT_W  number of samples with nonzero error
err_sum  out  ACC_W  saturating sum of error distances
err_max  out  PW  largest error distance in the window
sample_count  out  CNT_W  samples accepted (equals WINDOW at report)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE. in_ready=0, busy=0, res_valid=0. All result outputs, counters, accumulators and pipeline valids are 0. Reset asserted mid-window discards all partial results; no report is produced.
- States:
  - IDLE: waits for start=1, then moves to RUN and clears the accumulators and counters in the same edge.
  - RUN: in_ready=1 while accepted < WINDOW. A sample is accepted when in_valid & in_ready. When the WINDOW-th sample is accepted, go to DRAIN on the next edge; in_ready drops to 0 in the cycle after that acceptance.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty, at most 2 cycles, then go to REPORT.
  - REPORT: res_valid=1. err_count, err_sum, err_max and sample_count are held stable until res_valid & res_ready. On that edge go to IDLE and drop res_valid.
- start outside IDLE is ignored. start and rst in the same cycle: reset wins.
- Pipeline:
  - Stage 1 registers exact = in_a*in_b (full PW bits, unsigned) and ed = |in_approx - exact| (unsigned, PW bits).
  - Stage 2 updates the statistics from the stage-1 result:
    - err_sum += ed, saturating at 2^ACC_W-1 with no wrap.
    - err_count += 1 if ed != 0.
    - err_max = max(err_max, ed).
  - Accept-to-accumulate latency is 2 cycles, fully pipelined at 1 sample/cycle. Bubbles (in_valid=0) do not disturb the statistics.
- sample_count increments on acceptance, not on accumulation.
- WINDOW=1: one accept, then DRAIN, then REPORT.
- The internal accepted counter never exceeds WINDOW. Samples offered while in_ready=0 are neither counted nor accumulated.
- Result outputs retain their last reported values in IDLE, until the next start clears them.

Test Plan:
1. WINDOW=4, start, then four samples with in_approx equal to the exact product (3*5=15, 0*0=0, 255*255=65025, 16*16=256) -> REPORT with err_count=0, err_sum=0, err_max=0, sample_count=4.
2. WINDOW=4, samples with ed = 25 (255*255 with approx 65000), 0, 3 (7*9 with approx 60), 100 (200*100 with approx 20100) -> err_count=3, err_sum=128, err_max=100.
3. Backpressure: in scenario 2, hold res_ready=0 for 10 cycles -> res_valid stays 1 with all results stable. Raise res_ready -> one-cycle handshake, then IDLE.
4. ACC_W=16, WINDOW=4, each sample with ed=30000 -> err_sum saturates at 65535, err_max=30000, err_count=4.
5. Toggle in_valid every other cycle and pulse start while in RUN -> start is ignored, statistics are identical to back-to-back input, and in_ready=0 after the 4th accept.
6. Assert rst after 2 of 4 samples -> next cycle all outputs are 0 and state is IDLE. A new start and a full window report only the new samples.

Source files
------------

// File: rtl/approx_mult_error_monitor.sv
// Error monitor for an 8x8 approximate multiplier: accumulates error-distance
// statistics over a fixed window of samples and reports them via valid/ready.
module approx_mult_error_monitor #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CNT_W  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2*WIDTH-1:0]   in_approx,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_W-1:0]     err_count,
  output logic [ACC_W-1:0]     err_sum,
  output logic [2*WIDTH-1:0]   err_max,
  output logic [CNT_W-1:0]     sample_count
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t         state;
  logic           s1_valid;
  logic [PW-1:0]  s1_ed;

  logic           accept;
  logic           last;
  logic [PW-1:0]  exact;
  logic [PW-1:0]  ed_next;
  logic [SW-1:0]  sum_ext;

  // Exact product and absolute error distance of the sample being accepted.
  assign accept  = in_valid & in_ready;
  assign last    = (sample_count == CNT_W'(WINDOW - 1));
  assign exact   = PW'(in_a) * PW'(in_b);
  assign ed_next = (in_approx >= exact) ? (in_approx - exact) : (exact - in_approx);
  // One extra bit exposes the carry used for saturation.
  assign sum_ext = {1'b0, err_sum} + SW'(s1_ed);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      s1_valid     <= 1'b0;
      s1_ed        <= '0;
      err_count    <= '0;
      err_sum      <= '0;
      err_max      <= '0;
      sample_count <= '0;
    end else begin
      // Stage 1: capture the error distance of an accepted sample.
      s1_valid <= accept;
      if (accept) begin
        s1_ed        <= ed_next;
        sample_count <= sample_count + CNT_W'(1);
      end

      // Stage 2: fold the stage-1 result into the window statistics.
      if (s1_valid) begin
        err_sum <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        if (s1_ed != '0) err_count <= err_count + CNT_W'(1);
        if (s1_ed > err_max) err_max <= s1_ed;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            err_count    <= '0;
            err_sum      <= '0;
            err_max      <= '0;
            sample_count <= '0;
          end
        end
        RUN: begin
          if (accept && last) begin
            in_ready <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            res_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
